// File: rtl/io_uart_tx_if.sv
// Core-side I/O bus of the UART transmitter: strobes, register select and data.
// The core drives the strobes/address/write data; the port drives read data.
interface io_uart_tx_if;
    logic        ioW;
    logic        ioR;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output ioW,
        output ioR,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  ioW,
        input  ioR,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: core writes bytes into a small FIFO,
// an FSM shifts them out LSB first; status is polled through the read path.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    io_uart_tx_if.slave  bus,
    output logic         tx,
    output logic         busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_baud;
    logic [15:0]       w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_pop;
    logic              w_shift_en;
    logic              w_push_req;
    logic              w_push;
    logic              w_clr_ovf;
    logic              w_full;
    logic              w_empty;
    logic [3:0]        w_count4;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_count4   = 4'(r_count);
    assign w_push_req = bus.ioW && (bus.addr == 4'd0);
    assign w_push     = w_push_req && !w_full;
    assign w_clr_ovf  = bus.ioW && (bus.addr == 4'd1) && bus.wdata[0];

    // Read path is zero when not strobed so it can be ORed onto the core bus.
    always_comb begin
        bus.rdata = 16'h0000;
        if (bus.ioR && bus.addr == 4'd1) begin
            bus.rdata = {8'h00, w_count4, busy, r_ovf, w_empty, w_full};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            // A dropped byte outranks a firmware clear on the same edge.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_pop          = 1'b0;
        w_shift_en     = 1'b0;
        tx             = 1'b1;
        busy           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_baud_next  = BAUD_MAX;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (r_baud == 16'd0) begin
                    w_baud_next    = BAUD_MAX;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                tx   = r_shift[0];
                busy = 1'b1;
                if (r_baud == 16'd0) begin
                    w_baud_next = BAUD_MAX;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_en     = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                busy = 1'b1;
                // Chain straight into the next start bit when more data waits.
                if (r_baud == 16'd0) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_baud_next  = BAUD_MAX;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped serial output port on the processor's I/O strobes (ioW/ioR); sits directly downstream of the processor core.
- Core writes bytes through its I/O path. Bytes are buffered in a small FIFO and shifted out as 8N1 UART frames.
- Status is readable back onto the core's I/O read path, so firmware can poll full/empty/overflow.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, byte entries in the TX FIFO; legal values 2, 4, 8.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ioW  in  1  I/O write strobe from control.
- ioR  in  1  I/O read strobe from control.
- addr  in  4  register select, taken from instr[3:0] by the core.
- wdata  in  16  write data; only [7:0] used for data.
- rdata  out  16  read data to the core's data bus.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is on the line.

Behaviour:
- Reset (rst=1 at an edge) returns the block to its initial state:
  - FIFO empty, count=0, overflow=0.
  - FSM=IDLE, baud counter=0, bit index=0.
  - tx=1, busy=0.
  - Reset mid-frame aborts the frame: tx=1 on the next cycle, FIFO contents discarded.
- Register map:
  - addr 0 DATA:
    - Write pushes wdata[7:0] into the FIFO.
    - Read returns 16'h0000.
  - addr 1 STATUS:
    - Read returns {8'h00, count[3:0], busy, overflow, empty, full}, i.e. bit0=full, bit1=empty, bit2=overflow, bit3=busy, bits7:4=count.
    - Write with wdata[0]=1 clears overflow; other bits are ignored.
  - Other addr: writes ignored, reads return 0.
- rdata is combinational:
  - Equals the selected register when ioR=1.
  - Is 0 when ioR=0, so it can be ORed onto the core bus.
- FIFO:
  - Circular buffer with wrapping read/write pointers; count ranges 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Push to DATA while full (evaluated on the pre-edge count) drops the byte and sets overflow (sticky). This holds even if a pop occurs on the same edge.
  - Push and pop on the same edge with count not full and not empty: count unchanged, both take effect.
  - Push while empty: accepted. The pop happens at the earliest on the next edge.
  - overflow set and clear on the same edge: set wins.
- TX FSM, states IDLE -> START -> DATA -> STOP:
  - IDLE: tx=1, busy=0. If !empty at an edge: pop the head byte into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At its final cycle, if !empty: pop and go directly to START (no idle gap; back-to-back frames).
    - Otherwise go to IDLE.
  - busy=1 in START, DATA and STOP.
- Timing and latency:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Write sampled at edge E0 with the FSM idle: pop at E1, tx low from E1 onward.
- ioW and ioR asserted together: both occur; the read reflects pre-edge state.

Test Plan:
- Reset: hold rst 2 cycles -> tx=1, busy=0, STATUS read = 16'h0002.
- Single byte, CLKS_PER_BIT=4: write 0x00A5 to addr 0 at E0 -> tx low E1..E4, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, busy falls at E41, STATUS=0x0002.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles -> second start bit begins immediately after the first stop bit, no extra idle cycle, 80 cycles total busy.
- Overflow, DEPTH=8, CLKS_PER_BIT=100:
  - Write 10 bytes in 10 cycles -> first pops at once, FIFO reaches full.
  - 10th write dropped: STATUS shows full=1, overflow=1, count=8.
  - Write 1 to addr 1 -> overflow=0.
- Simultaneous push/pop:
  - Push coinciding with the pop at a frame end, count=3 -> count stays 3, byte order preserved on the line.
  - Push while full coinciding with a pop -> byte dropped, count=7, overflow=1.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 next cycle, empty=1, no further frames.
